// File: rtl/add8_wide_seq.sv
// Byte-serial wide adder sequencer around a shared 8-bit registered adder (1-cycle latency).
// Optional subtract mode: define ADD8_WIDE_SEQ_SUB_EN to add the in_sub port.
module add8_wide_seq #(
  parameter int NBYTES = 4,
  localparam int W = 8 * NBYTES
) (
  input  logic         clk_100M,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_cin,
`ifdef ADD8_WIDE_SEQ_SUB_EN
  input  logic         in_sub,
`endif
  output logic         add_cin,
  output logic [7:0]   add_cina,
  output logic [7:0]   add_cinb,
  input  logic [7:0]   add_sum,
  input  logic         add_cout,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         out_cout
);

  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, acc_q, acc_d, sum_q, sum_d;
  logic [IW-1:0]   idx_q, idx_d, nidx;
  logic            carry_q, carry_d, cout_q, cout_d;
  logic            in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic            add_cin_q, add_cin_d;
  logic [7:0]      add_cina_q, add_cina_d, add_cinb_q, add_cinb_d;
  logic [W-1:0]    b_in;
  logic            cin_in;

  // Subtraction is a + ~b + 1; inverting b once at acceptance covers every slice.
`ifdef ADD8_WIDE_SEQ_SUB_EN
  assign b_in   = in_sub ? ~in_b : in_b;
  assign cin_in = in_sub ? 1'b1 : in_cin;
`else
  assign b_in   = in_b;
  assign cin_in = in_cin;
`endif

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    sum_d       = sum_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    cout_d      = cout_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    add_cin_d   = 1'b0;
    add_cina_d  = 8'h00;
    add_cinb_d  = 8'h00;
    nidx        = idx_q + 1'b1;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d        = in_a;
          b_d        = b_in;
          carry_d    = cin_in;
          idx_d      = '0;
          in_ready_d = 1'b0;
          // Adder inputs are registered on entry to ISSUE so the adder sees them during ISSUE.
          add_cina_d = in_a[7:0];
          add_cinb_d = b_in[7:0];
          add_cin_d  = cin_in;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_CAPTURE;
      S_CAPTURE: begin
        acc_d[8*idx_q +: 8] = add_sum;
        carry_d = add_cout;
        if (idx_q == IW'(NBYTES - 1)) begin
          sum_d       = acc_d;
          cout_d      = add_cout;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          idx_d      = nidx;
          add_cina_d = a_q[8*nidx +: 8];
          add_cinb_d = b_q[8*nidx +: 8];
          add_cin_d  = add_cout;
          state_d    = S_ISSUE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_100M) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      sum_q       <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      add_cin_q   <= 1'b0;
      add_cina_q  <= 8'h00;
      add_cinb_q  <= 8'h00;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      sum_q       <= sum_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      cout_q      <= cout_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      add_cin_q   <= add_cin_d;
      add_cina_q  <= add_cina_d;
      add_cinb_q  <= add_cinb_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign add_cin   = add_cin_q;
  assign add_cina  = add_cina_q;
  assign add_cinb  = add_cinb_q;

endmodule

// File: tb/tb_add8_wide_seq.sv
// Directed bench for add8_wide_seq with a behavioural 8-bit registered adder attached.
module tb_add8_wide_seq;
  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic         clk, rst, in_valid, in_ready, in_cin, out_valid, out_ready, out_cout;
  logic [W-1:0] in_a, in_b, out_sum;
  logic         add_cin, add_cout;
  logic [7:0]   add_cina, add_cinb, add_sum;
`ifdef ADD8_WIDE_SEQ_SUB_EN
  logic         in_sub;
`endif

  int nchk = 0;
  int nerr = 0;

  add8_wide_seq #(.NBYTES(NB)) dut (
    .clk_100M(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
`ifdef ADD8_WIDE_SEQ_SUB_EN
    .in_sub(in_sub),
`endif
    .add_cin(add_cin), .add_cina(add_cina), .add_cinb(add_cinb),
    .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared adder: registered, one-cycle latency.
  always @(posedge clk) begin
    if (rst) {add_cout, add_sum} <= 9'h000;
    else     {add_cout, add_sum} <= {1'b0, add_cina} + {1'b0, add_cinb} + {8'h00, add_cin};
  end

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    int           hold;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v, input string nm);
    int k;
    logic [W-1:0] held;
    k = 0;
    while (!in_ready && k < 20) begin @(posedge clk); #1; k++; end
    chk({nm, ".ready"}, 64'(in_ready), 64'd1);
    @(negedge clk);
    in_a = v.a; in_b = v.b; in_cin = v.cin; in_valid = 1'b1;
`ifdef ADD8_WIDE_SEQ_SUB_EN
    in_sub = v.sub;
`endif
    @(posedge clk); #1;
    // Operands are scrambled after acceptance; the latched copy must be used.
    in_valid = 1'b0; in_a = ~v.a; in_b = ~v.b; in_cin = ~v.cin;
`ifdef ADD8_WIDE_SEQ_SUB_EN
    in_sub = ~v.sub;
`endif
    k = 0;
    while (!out_valid && k < 20) begin @(posedge clk); #1; k++; end
    chk({nm, ".latency"}, 64'(k), 64'(2 * NB));
    chk({nm, ".sum"}, 64'(out_sum), 64'(v.exp_sum));
    chk({nm, ".cout"}, 64'(out_cout), 64'(v.exp_cout));
    chk({nm, ".adder_idle"}, 64'({add_cin, add_cina, add_cinb}), 64'd0);
    held = out_sum;
    for (int i = 0; i < v.hold; i++) begin
      @(posedge clk); #1;
      chk({nm, ".hold_valid"}, 64'(out_valid), 64'd1);
      chk({nm, ".hold_sum"}, 64'(out_sum), 64'(held));
      chk({nm, ".hold_inready"}, 64'(in_ready), 64'd0);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    chk({nm, ".post_valid"}, 64'(out_valid), 64'd0);
    chk({nm, ".post_ready"}, 64'(in_ready), 64'd1);
    chk({nm, ".post_sum"}, 64'(out_sum), 64'(v.exp_sum));
  endtask

  vec_t vecs[7];
  vec_t v;

  initial begin
    vecs[0] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 0, 32'h00000000, 1'b1};
    vecs[1] = '{32'h12345678, 32'h11111111, 1'b0, 1'b0, 5, 32'h23456789, 1'b0};
    vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 0, 32'hFFFFFFFF, 1'b1};
    vecs[3] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 0, 32'h00000000, 1'b1};
    vecs[4] = '{32'h000000FF, 32'h00000001, 1'b0, 1'b0, 0, 32'h00000100, 1'b0};
    vecs[5] = '{32'h00000000, 32'h00000000, 1'b0, 1'b0, 0, 32'h00000000, 1'b0};
    vecs[6] = '{32'hDEADBEEF, 32'h01234567, 1'b1, 1'b0, 2, 32'hDFD10457, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0;
`ifdef ADD8_WIDE_SEQ_SUB_EN
    in_sub = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("rst.in_ready", 64'(in_ready), 64'd1);
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.out_sum", 64'(out_sum), 64'd0);
    chk("rst.out_cout", 64'(out_cout), 64'd0);
    chk("rst.adder", 64'({add_cin, add_cina, add_cinb}), 64'd0);

    // out_ready outside DONE must not disturb IDLE.
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    chk("idle_oready.in_ready", 64'(in_ready), 64'd1);
    chk("idle_oready.out_valid", 64'(out_valid), 64'd0);

    for (int i = 0; i < 7; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    // Abort during the third CAPTURE: accept edge, then 5 edges reach CAPTURE of byte 2.
    @(negedge clk);
    in_a = 32'h0F0F0F0F; in_b = 32'h01010101; in_cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    chk("midrst.in_ready", 64'(in_ready), 64'd1);
    chk("midrst.out_valid", 64'(out_valid), 64'd0);
    chk("midrst.out_sum", 64'(out_sum), 64'd0);
    chk("midrst.adder", 64'({add_cin, add_cina, add_cinb}), 64'd0);
    v = '{32'h00000001, 32'h00000001, 1'b0, 1'b0, 0, 32'h00000002, 1'b0};
    run_op(v, "after_rst");

`ifdef ADD8_WIDE_SEQ_SUB_EN
    v = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 0, 32'hFFFFFFFE, 1'b0};
    run_op(v, "sub_5_7");
    v = '{32'h00000007, 32'h00000005, 1'b1, 1'b1, 0, 32'h00000002, 1'b1};
    run_op(v, "sub_7_5");
    v = '{32'h12345678, 32'h11111111, 1'b0, 1'b0, 0, 32'h23456789, 1'b0};
    run_op(v, "sub_off_add");
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end
endmodule
